// File: rtl/ctrl_pkg.sv
// Shared definitions for the multi-cycle control unit and the ALU control decoder.
package ctrl_pkg;

    // Instruction opcodes (IR[15:12])
    localparam logic [3:0] OP_LD       = 4'b0000;
    localparam logic [3:0] OP_ST       = 4'b0001;
    localparam logic [3:0] OP_RTYPE_LO = 4'b0010;
    localparam logic [3:0] OP_RTYPE_HI = 4'b1010;
    localparam logic [3:0] OP_BEQ      = 4'b1011;
    localparam logic [3:0] OP_BNE      = 4'b1100;
    localparam logic [3:0] OP_JMP      = 4'b1101;

    // ALUOp values consumed by the ALU control decoder
    localparam logic [1:0] ALUOP_RTYPE = 2'b00;
    localparam logic [1:0] ALUOP_BR    = 2'b01;
    localparam logic [1:0] ALUOP_MEM   = 2'b10;

    // PC source select
    localparam logic [1:0] PCSEL_INC = 2'b00;
    localparam logic [1:0] PCSEL_BR  = 2'b01;
    localparam logic [1:0] PCSEL_JMP = 2'b10;

    // Controller states; codes 5-7 are unused and recover to FETCH
    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEM    = 3'd3,
        ST_WB     = 3'd4
    } state_e;

    // Bundle of every control output driven by the FSM
    typedef struct packed {
        logic       imem_req;
        logic       dmem_req;
        logic       dmem_we;
        logic       ir_we;
        logic       pc_we;
        logic [1:0] pc_sel;
        logic [1:0] alu_op;
        logic       alu_src;
        logic       reg_we;
        logic       mem_to_reg;
        logic       reg_dst;
        logic       instr_done;
        logic       illegal_op;
        logic       bus_err;
    } ctrl_out_t;

    localparam ctrl_out_t CTRL_IDLE = ctrl_out_t'(16'h0000);

    // Opcodes 1110 and 1111 are not defined in the ISA
    function automatic logic is_illegal(input logic [3:0] op);
        return (op[3:1] == 3'b111);
    endfunction

endpackage

// File: rtl/mem_wait_watchdog.sv
// Counts cycles a memory request has waited for its ack and flags the timeout.
module mem_wait_watchdog #(
    parameter int WAIT_LIMIT = 15,
    parameter int CNT_W      = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr_i,      // controller changes state this cycle
    input  logic             wait_i,     // request outstanding with no ack
    output logic [CNT_W-1:0] wait_cnt_o,
    output logic             expired_o   // this wait cycle hits the limit
);

    localparam logic [CNT_W-1:0] CNT_ZERO  = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(WAIT_LIMIT);

    logic [CNT_W-1:0] wait_cnt_q;
    logic [CNT_W-1:0] wait_cnt_d;
    logic             expired_s;

    // Timeout only fires on a genuine wait cycle, so an ack in the limit cycle wins
    always_comb begin
        expired_s = wait_i && (wait_cnt_q == CNT_LIMIT);
    end

    // Next count: clear on state change or timeout, otherwise count wait cycles
    always_comb begin
        wait_cnt_d = wait_cnt_q;
        if (clr_i || expired_s) begin
            wait_cnt_d = CNT_ZERO;
        end else if (wait_i) begin
            wait_cnt_d = wait_cnt_q + CNT_ONE;
        end else begin
            wait_cnt_d = wait_cnt_q;
        end
    end

    // Wait counter register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt_q <= CNT_ZERO;
        end else begin
            wait_cnt_q <= wait_cnt_d;
        end
    end

    assign wait_cnt_o = wait_cnt_q;
    assign expired_o  = expired_s;

endmodule

// File: rtl/multicycle_ctrl_fsm.sv
// Multi-cycle main control unit: FETCH/DECODE/EXEC/MEM/WB sequencer for the 16-bit core.
module multicycle_ctrl_fsm
    import ctrl_pkg::*;
#(
    parameter int WAIT_LIMIT = 15,
    parameter int CNT_W      = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] ir_opcode,
    input  logic       alu_zero,
    input  logic       imem_ack,
    input  logic       dmem_ack,
    output logic       imem_req,
    output logic       dmem_req,
    output logic       dmem_we,
    output logic       ir_we,
    output logic       pc_we,
    output logic [1:0] pc_sel,
    output logic [1:0] alu_op,
    output logic       alu_src,
    output logic       reg_we,
    output logic       mem_to_reg,
    output logic       reg_dst,
    output logic       instr_done,
    output logic       illegal_op,
    output logic       bus_err,
    output logic [2:0] state
);

    state_e           state_q;
    state_e           state_d;
    logic [3:0]       op_q;
    logic [3:0]       op_d;
    logic             wait_s;
    logic             clr_s;
    logic             expired_s;
    logic [CNT_W-1:0] wait_cnt_s;
    ctrl_out_t        ctrl_s;
    ctrl_out_t        out_s;

    // A wait cycle is a memory request still lacking its ack
    always_comb begin
        case (state_q)
            ST_FETCH: wait_s = !imem_ack;
            ST_MEM:   wait_s = !dmem_ack;
            default:  wait_s = 1'b0;
        endcase
    end

    // Any state change restarts the wait count for the next request
    always_comb begin
        clr_s = (state_d != state_q);
    end

    mem_wait_watchdog #(
        .WAIT_LIMIT (WAIT_LIMIT),
        .CNT_W      (CNT_W)
    ) u_watchdog (
        .clk        (clk),
        .rst_n      (rst_n),
        .clr_i      (clr_s),
        .wait_i     (wait_s),
        .wait_cnt_o (wait_cnt_s),
        .expired_o  (expired_s)
    );

    // Next-state, opcode latch and control outputs from state and latched opcode
    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        ctrl_s  = CTRL_IDLE;
        case (state_q)
            ST_FETCH: begin
                ctrl_s.imem_req = 1'b1;
                if (imem_ack) begin
                    ctrl_s.ir_we  = 1'b1;
                    ctrl_s.pc_we  = 1'b1;
                    ctrl_s.pc_sel = PCSEL_INC;
                    state_d       = ST_DECODE;
                end else if (expired_s) begin
                    ctrl_s.bus_err = 1'b1;
                    state_d        = ST_FETCH;
                end else begin
                    state_d = ST_FETCH;
                end
            end
            ST_DECODE: begin
                op_d = ir_opcode;
                if (is_illegal(ir_opcode)) begin
                    ctrl_s.illegal_op = 1'b1;
                    state_d           = ST_FETCH;
                end else begin
                    state_d = ST_EXEC;
                end
            end
            ST_EXEC: begin
                if ((op_q == OP_LD) || (op_q == OP_ST)) begin
                    ctrl_s.alu_op  = ALUOP_MEM;
                    ctrl_s.alu_src = 1'b1;
                    state_d        = ST_MEM;
                end else if ((op_q >= OP_RTYPE_LO) && (op_q <= OP_RTYPE_HI)) begin
                    ctrl_s.alu_op  = ALUOP_RTYPE;
                    ctrl_s.alu_src = 1'b0;
                    state_d        = ST_WB;
                end else if (op_q == OP_BEQ) begin
                    ctrl_s.alu_op     = ALUOP_BR;
                    ctrl_s.pc_we      = alu_zero;
                    ctrl_s.pc_sel     = alu_zero ? PCSEL_BR : PCSEL_INC;
                    ctrl_s.instr_done = 1'b1;
                    state_d           = ST_FETCH;
                end else if (op_q == OP_BNE) begin
                    ctrl_s.alu_op     = ALUOP_BR;
                    ctrl_s.pc_we      = !alu_zero;
                    ctrl_s.pc_sel     = alu_zero ? PCSEL_INC : PCSEL_BR;
                    ctrl_s.instr_done = 1'b1;
                    state_d           = ST_FETCH;
                end else if (op_q == OP_JMP) begin
                    ctrl_s.pc_we      = 1'b1;
                    ctrl_s.pc_sel     = PCSEL_JMP;
                    ctrl_s.instr_done = 1'b1;
                    state_d           = ST_FETCH;
                end else begin
                    // Illegal opcodes never reach EXEC; recover defensively
                    state_d = ST_FETCH;
                end
            end
            ST_MEM: begin
                ctrl_s.dmem_req = 1'b1;
                ctrl_s.dmem_we  = (op_q == OP_ST);
                ctrl_s.alu_op   = ALUOP_MEM;
                ctrl_s.alu_src  = 1'b1;
                if (dmem_ack) begin
                    if (op_q == OP_ST) begin
                        ctrl_s.instr_done = 1'b1;
                        state_d           = ST_FETCH;
                    end else begin
                        state_d = ST_WB;
                    end
                end else if (expired_s) begin
                    ctrl_s.bus_err = 1'b1;
                    state_d        = ST_FETCH;
                end else begin
                    state_d = ST_MEM;
                end
            end
            ST_WB: begin
                ctrl_s.reg_we     = 1'b1;
                ctrl_s.instr_done = 1'b1;
                ctrl_s.mem_to_reg = (op_q == OP_LD);
                ctrl_s.reg_dst    = (op_q != OP_LD);
                state_d           = ST_FETCH;
            end
            default: begin
                state_d = ST_FETCH;
            end
        endcase
    end

    // While reset is asserted every output is forced low, so a held-in-reset
    // controller never issues a memory request
    always_comb begin
        if (rst_n) begin
            out_s = ctrl_s;
        end else begin
            out_s = CTRL_IDLE;
        end
    end

    // State and latched opcode registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_FETCH;
            op_q    <= 4'b0000;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
        end
    end

    assign imem_req   = out_s.imem_req;
    assign dmem_req   = out_s.dmem_req;
    assign dmem_we    = out_s.dmem_we;
    assign ir_we      = out_s.ir_we;
    assign pc_we      = out_s.pc_we;
    assign pc_sel     = out_s.pc_sel;
    assign alu_op     = out_s.alu_op;
    assign alu_src    = out_s.alu_src;
    assign reg_we     = out_s.reg_we;
    assign mem_to_reg = out_s.mem_to_reg;
    assign reg_dst    = out_s.reg_dst;
    assign instr_done = out_s.instr_done;
    assign illegal_op = out_s.illegal_op;
    assign bus_err    = out_s.bus_err;
    assign state      = state_q;

    // The counter value is only consumed inside the watchdog compare
    logic unused_s;
    assign unused_s = ^wait_cnt_s;

endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
// Directed self-checking bench for multicycle_ctrl_fsm.
module tb_multicycle_ctrl_fsm;

    logic       clk;
    logic       rst_n;
    logic [3:0] ir_opcode;
    logic       alu_zero;
    logic       imem_ack;
    logic       dmem_ack;
    logic       imem_req;
    logic       dmem_req;
    logic       dmem_we;
    logic       ir_we;
    logic       pc_we;
    logic [1:0] pc_sel;
    logic [1:0] alu_op;
    logic       alu_src;
    logic       reg_we;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       instr_done;
    logic       illegal_op;
    logic       bus_err;
    logic [2:0] state;

    int n_total;
    int n_pass;

    multicycle_ctrl_fsm #(
        .WAIT_LIMIT (15),
        .CNT_W      (4)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .ir_opcode  (ir_opcode),
        .alu_zero   (alu_zero),
        .imem_ack   (imem_ack),
        .dmem_ack   (dmem_ack),
        .imem_req   (imem_req),
        .dmem_req   (dmem_req),
        .dmem_we    (dmem_we),
        .ir_we      (ir_we),
        .pc_we      (pc_we),
        .pc_sel     (pc_sel),
        .alu_op     (alu_op),
        .alu_src    (alu_src),
        .reg_we     (reg_we),
        .mem_to_reg (mem_to_reg),
        .reg_dst    (reg_dst),
        .instr_done (instr_done),
        .illegal_op (illegal_op),
        .bus_err    (bus_err),
        .state      (state)
    );

    // 10 ns clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // Inputs change on the falling edge; outputs are checked 1 ns later
    initial begin
        n_total   = 0;
        n_pass    = 0;
        rst_n     = 1'b0;
        ir_opcode = 4'b0000;
        alu_zero  = 1'b0;
        imem_ack  = 1'b0;
        dmem_ack  = 1'b0;

        // Reset state
        #3;
        chk("rst_state", {1'b0, state}, 4'd0);
        chk("rst_imem_req", {3'b000, imem_req}, 4'd0);
        chk("rst_alu_op", {2'b00, alu_op}, 4'd0);
        chk("rst_pc_sel", {2'b00, pc_sel}, 4'd0);

        // Release: first cycle fetches
        @(negedge clk); rst_n = 1'b1; #1;
        chk("rel_state", {1'b0, state}, 4'd0);
        chk("rel_imem_req", {3'b000, imem_req}, 4'd1);

        // ADD, zero-wait: 0,1,2,4,0
        imem_ack = 1'b1; ir_opcode = 4'b0010; #1;
        chk("add_f_ir_we", {3'b000, ir_we}, 4'd1);
        chk("add_f_pc_we", {3'b000, pc_we}, 4'd1);
        chk("add_f_pc_sel", {2'b00, pc_sel}, 4'd0);
        @(negedge clk); imem_ack = 1'b0; #1;
        chk("add_d_state", {1'b0, state}, 4'd1);
        chk("add_d_imem_req", {3'b000, imem_req}, 4'd0);
        @(negedge clk); #1;
        chk("add_e_state", {1'b0, state}, 4'd2);
        chk("add_e_alu_op", {2'b00, alu_op}, 4'd0);
        chk("add_e_alu_src", {3'b000, alu_src}, 4'd0);
        @(negedge clk); #1;
        chk("add_w_state", {1'b0, state}, 4'd4);
        chk("add_w_reg_we", {3'b000, reg_we}, 4'd1);
        chk("add_w_reg_dst", {3'b000, reg_dst}, 4'd1);
        chk("add_w_done", {3'b000, instr_done}, 4'd1);
        @(negedge clk); #1;
        chk("add_end_state", {1'b0, state}, 4'd0);

        // LD with dmem_ack delayed 3 cycles
        imem_ack = 1'b1; ir_opcode = 4'b0000; #1;
        @(negedge clk); imem_ack = 1'b0; #1;
        @(negedge clk); #1;
        chk("ld_e_alu_op", {2'b00, alu_op}, 4'd2);
        chk("ld_e_alu_src", {3'b000, alu_src}, 4'd1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); #1;
            chk("ld_m_state", {1'b0, state}, 4'd3);
            chk("ld_m_dmem_req", {3'b000, dmem_req}, 4'd1);
            chk("ld_m_dmem_we", {3'b000, dmem_we}, 4'd0);
        end
        @(negedge clk); dmem_ack = 1'b1; #1;
        chk("ld_m4_state", {1'b0, state}, 4'd3);
        chk("ld_m4_done", {3'b000, instr_done}, 4'd0);
        @(negedge clk); dmem_ack = 1'b0; #1;
        chk("ld_w_state", {1'b0, state}, 4'd4);
        chk("ld_w_mem_to_reg", {3'b000, mem_to_reg}, 4'd1);
        chk("ld_w_reg_dst", {3'b000, reg_dst}, 4'd0);
        chk("ld_w_done", {3'b000, instr_done}, 4'd1);
        @(negedge clk); #1;
        chk("ld_end_state", {1'b0, state}, 4'd0);

        // BEQ taken
        imem_ack = 1'b1; ir_opcode = 4'b1011; #1;
        @(negedge clk); imem_ack = 1'b0; #1;
        @(negedge clk); alu_zero = 1'b1; #1;
        chk("beq_alu_op", {2'b00, alu_op}, 4'd1);
        chk("beq_pc_we", {3'b000, pc_we}, 4'd1);
        chk("beq_pc_sel", {2'b00, pc_sel}, 4'd1);
        chk("beq_done", {3'b000, instr_done}, 4'd1);
        @(negedge clk); alu_zero = 1'b0; #1;
        chk("beq_end_state", {1'b0, state}, 4'd0);

        // BNE with zero set: not taken
        imem_ack = 1'b1; ir_opcode = 4'b1100; #1;
        @(negedge clk); imem_ack = 1'b0; #1;
        @(negedge clk); alu_zero = 1'b1; #1;
        chk("bne_alu_op", {2'b00, alu_op}, 4'd1);
        chk("bne_pc_we", {3'b000, pc_we}, 4'd0);
        chk("bne_done", {3'b000, instr_done}, 4'd1);
        @(negedge clk); alu_zero = 1'b0; #1;
        chk("bne_end_state", {1'b0, state}, 4'd0);

        // JMP
        imem_ack = 1'b1; ir_opcode = 4'b1101; #1;
        @(negedge clk); imem_ack = 1'b0; #1;
        @(negedge clk); #1;
        chk("jmp_pc_we", {3'b000, pc_we}, 4'd1);
        chk("jmp_pc_sel", {2'b00, pc_sel}, 4'd2);
        chk("jmp_done", {3'b000, instr_done}, 4'd1);
        @(negedge clk); #1;
        chk("jmp_end_state", {1'b0, state}, 4'd0);

        // Illegal opcode 1111
        imem_ack = 1'b1; ir_opcode = 4'b1111; #1;
        @(negedge clk); imem_ack = 1'b0; #1;
        chk("ill_illegal_op", {3'b000, illegal_op}, 4'd1);
        chk("ill_reg_we", {3'b000, reg_we}, 4'd0);
        chk("ill_dmem_req", {3'b000, dmem_req}, 4'd0);
        @(negedge clk); #1;
        chk("ill_end_state", {1'b0, state}, 4'd0);
        chk("ill_pulse_gone", {3'b000, illegal_op}, 4'd0);

        // ST zero-wait
        imem_ack = 1'b1; ir_opcode = 4'b0001; #1;
        @(negedge clk); imem_ack = 1'b0; #1;
        @(negedge clk); #1;
        @(negedge clk); dmem_ack = 1'b1; #1;
        chk("st_m_dmem_we", {3'b000, dmem_we}, 4'd1);
        chk("st_m_done", {3'b000, instr_done}, 4'd1);
        @(negedge clk); dmem_ack = 1'b0; #1;
        chk("st_end_state", {1'b0, state}, 4'd0);

        // Fetch timeout: 15 wait cycles, bus_err on the 16th
        for (int i = 0; i < 15; i++) begin
            chk("to_no_err", {3'b000, bus_err}, 4'd0);
            @(negedge clk); #1;
        end
        chk("to_bus_err", {3'b000, bus_err}, 4'd1);
        chk("to_ir_we", {3'b000, ir_we}, 4'd0);
        chk("to_pc_we", {3'b000, pc_we}, 4'd0);
        @(negedge clk); #1;
        chk("to_refetch_state", {1'b0, state}, 4'd0);
        chk("to_refetch_req", {3'b000, imem_req}, 4'd1);
        chk("to_err_cleared", {3'b000, bus_err}, 4'd0);

        // Re-fetch from a cleared count: ack in the limit cycle beats the timeout
        for (int i = 0; i < 14; i++) begin
            @(negedge clk); #1;
            chk("lim_no_err", {3'b000, bus_err}, 4'd0);
        end
        @(negedge clk); imem_ack = 1'b1; ir_opcode = 4'b1110; #1;
        chk("lim_bus_err", {3'b000, bus_err}, 4'd0);
        chk("lim_ir_we", {3'b000, ir_we}, 4'd1);
        @(negedge clk); imem_ack = 1'b0; #1;
        chk("lim_decode", {1'b0, state}, 4'd1);
        chk("lim_illegal_1110", {3'b000, illegal_op}, 4'd1);

        // Reset during MEM of a ST
        @(negedge clk); imem_ack = 1'b1; ir_opcode = 4'b0001; #1;
        @(negedge clk); imem_ack = 1'b0; #1;
        @(negedge clk); #1;
        @(negedge clk); #1;
        chk("rst_st_mem_state", {1'b0, state}, 4'd3);
        chk("rst_st_dmem_req", {3'b000, dmem_req}, 4'd1);
        #1; rst_n = 1'b0; #1;
        chk("rst_mid_dmem_req", {3'b000, dmem_req}, 4'd0);
        chk("rst_mid_state", {1'b0, state}, 4'd0);
        chk("rst_mid_imem_req", {3'b000, imem_req}, 4'd0);
        @(negedge clk); rst_n = 1'b1; #1;
        chk("rst_rel_state", {1'b0, state}, 4'd0);
        chk("rst_rel_imem_req", {3'b000, imem_req}, 4'd1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
